fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the 5-stage pipeline.
- Owns the PC register and drives the byte address into the combinational instruction memory. That memory returns its word in the same cycle.
- Captures the instruction into the IF/ID register and applies stall and redirect (branch/jump) requests from the hazard and EX units.
- Issues one fetch per cycle, inserts bubbles on redirect, and counts retired fetches for performance debug.

Parameters:
- ADDR_W, 14, byte-address width of the instruction memory port.
- RESET_PC, 14'h0000, PC loaded on reset (must be word aligned).
- CNT_W, 32, width of the fetch counter.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous active-high reset.
- o_imem_addr  output  ADDR_W  byte address to instruction memory; always equals the PC register.
- i_imem_rdata  input  32  instruction word from memory, valid in the same cycle as o_imem_addr.
- i_stall  input  1  hold the IF stage and IF/ID register.
- i_redirect  input  1  taken branch/jump; load the new PC.
- i_redirect_pc  input  ADDR_W  redirect target byte address.
- o_if_pc  output  ADDR_W  PC of the instruction in IF/ID.
- o_if_instr  output  32  instruction in IF/ID.
- o_if_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- o_misalign  output  1  one-cycle pulse: redirect target had bits[1:0] != 0.
- o_fetch_cnt  output  CNT_W  number of valid instructions loaded into IF/ID.

Behaviour:
- Reset, synchronous on the i_clk edge with i_rst=1:
  - pc=RESET_PC, state=S_BOOT.
  - o_if_pc=0, o_if_instr=32'h0000_0013 (NOP), o_if_valid=0.
  - o_misalign=0, o_fetch_cnt=0.
- Reset asserted mid-operation overrides all other inputs in that cycle.
- States:
  - S_BOOT: one cycle after reset release. The address is presented but nothing is captured, so o_if_valid stays 0. Moves to S_RUN unconditionally; i_stall and i_redirect are ignored in this state.
  - S_RUN: normal fetch.
  - S_STALL: entered when i_stall=1 and i_redirect=0. PC and IF/ID are held. Returns to S_RUN the first cycle i_stall=0.
- Per-cycle priority in S_RUN/S_STALL is redirect > stall > advance.
  - Redirect (regardless of i_stall):
    - pc <= {i_redirect_pc[ADDR_W-1:2],2'b00}.
    - o_if_valid <= 0; o_if_instr <= NOP; o_if_pc unchanged.
    - Next state is S_RUN.
    - o_misalign <= |i_redirect_pc[1:0].
  - Stall: all registers hold; o_misalign <= 0.
  - Advance:
    - o_if_instr <= i_imem_rdata; o_if_pc <= pc; o_if_valid <= 1.
    - pc <= pc + 4, wrapping modulo 2^ADDR_W (pc 14'h3FFC -> 14'h0000).
    - o_fetch_cnt <= o_fetch_cnt + 1, wrapping modulo 2^CNT_W.
- Fetch latency: the instruction at PC X appears in IF/ID one edge after pc=X with no stall. Throughput is one per cycle.
- Redirect penalty: one bubble from this block. Older wrong-path instructions already downstream are flushed by the hazard unit.
- The fetch counter increments only on the advance event. It does not change on bubbles or stalls.
- o_imem_addr is combinational from the pc register only, with no input-to-output combinational path.

Decomposition:
- Shared package pipe_pkg holds:
  - constant NOP_INSTR = 32'h0000_0013
  - typedef enum logic [1:0] fetch_state_e {S_BOOT, S_RUN, S_STALL}
  - typedef struct if_id_t {pc, instr, valid}
- No sub-module. PC update, FSM and IF/ID register are one always_ff plus one always_comb next-state block.

Test Plan:
- Reset, RESET_PC=0:
  - Cycle 0 after release: o_imem_addr=0, o_if_valid=0.
  - Memory words 0x00500093 and 0x00100113 then appear in IF/ID at pc 0 and 4 on successive cycles.
  - o_fetch_cnt=2 after two advances.
- i_stall=1 for 3 cycles at pc=0x10: o_imem_addr stays 0x10, IF/ID unchanged, o_fetch_cnt unchanged. Normal fetch of 0x10 resumes the cycle after i_stall drops.
- i_redirect=1, i_redirect_pc=0x40 while i_stall=1: next cycle pc=0x40, o_if_valid=0, o_if_instr=0x00000013. The following cycle IF/ID holds pc=0x40 with valid=1.
- i_redirect_pc=0x22: pc becomes 0x20 and o_misalign pulses high for exactly one cycle.
- Start pc at 0x3FFC with no stalls: next pc=0x0000; o_if_pc=0x3FFC captured with valid=1.
- Assert i_rst during a stall and a redirect in the same cycle: all outputs take their reset values, and S_BOOT is re-entered with one invalid cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline types and constants for the fetch stage.
//   NOP_INSTR      - canonical bubble instruction (addi x0,x0,0)
//   IF_PC_W        - width of the PC field carried in the IF/ID register
//   fetch_state_e  - fetch sequencer states
//   if_id_t        - IF/ID pipeline register contents
package pipe_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int IF_PC_W = 14;
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_STALL} fetch_state_e;
  typedef struct packed {
    logic [IF_PC_W-1:0] pc;
    logic [31:0]        instr;
    logic               valid;
  } if_id_t;
endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer owning the PC and the IF/ID register.
//   i_clk, i_rst            - clock, synchronous active-high reset
//   o_imem_addr             - byte address to combinational instruction memory (= PC)
//   i_imem_rdata            - instruction word for o_imem_addr, same cycle
//   i_stall                 - hold PC and IF/ID
//   i_redirect, i_redirect_pc - taken branch/jump and its target
//   o_if_pc, o_if_instr, o_if_valid - IF/ID register contents
//   o_misalign              - one-cycle pulse for a redirect target with bits[1:0] != 0
//   o_fetch_cnt             - count of valid instructions loaded into IF/ID
module fetch_ctrl
  import pipe_pkg::*;
#(
  parameter int              ADDR_W   = IF_PC_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic [31:0]       i_imem_rdata,
  input  logic              i_stall,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic [ADDR_W-1:0] o_if_pc,
  output logic [31:0]       o_if_instr,
  output logic              o_if_valid,
  output logic              o_misalign,
  output logic [CNT_W-1:0]  o_fetch_cnt
);
  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  if_id_t            ifid_q, ifid_d;
  logic              misalign_q, misalign_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ifid_d     = ifid_q;
    misalign_d = 1'b0;
    cnt_d      = cnt_q;
    if (state_q == S_BOOT) begin
      // Boot cycle presents RESET_PC to memory but captures nothing.
      state_d = S_RUN;
    end else if (i_redirect) begin
      // Redirect wins over stall; the target is forced to word alignment.
      state_d      = S_RUN;
      pc_d         = {i_redirect_pc[ADDR_W-1:2], 2'b00};
      ifid_d.instr = NOP_INSTR;
      ifid_d.valid = 1'b0;
      misalign_d   = |i_redirect_pc[1:0];
    end else if (i_stall) begin
      state_d = S_STALL;
    end else begin
      state_d      = S_RUN;
      ifid_d.pc    = IF_PC_W'(pc_q);
      ifid_d.instr = i_imem_rdata;
      ifid_d.valid = 1'b1;
      pc_d         = pc_q + ADDR_W'(4);
      cnt_d        = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      ifid_q     <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ifid_q     <= ifid_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_imem_addr = pc_q;
  assign o_if_pc     = ADDR_W'(ifid_q.pc);
  assign o_if_instr  = ifid_q.instr;
  assign o_if_valid  = ifid_q.valid;
  assign o_misalign  = misalign_q;
  assign o_fetch_cnt = cnt_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized and directed checking of fetch_ctrl against a behavioural model.
module tb_fetch_ctrl;
  localparam int AW = 14;
  localparam int CW = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          stall = 1'b0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [AW-1:0] if_pc;
  logic [31:0]   if_instr;
  logic          if_valid;
  logic          misalign;
  logic [CW-1:0] fetch_cnt;

  logic [31:0] mem [0:(1<<(AW-2))-1];

  int passed = 0;
  int total  = 0;

  fetch_ctrl #(.ADDR_W(AW), .RESET_PC('0), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_imem_addr(imem_addr), .i_imem_rdata(imem_rdata),
    .i_stall(stall), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_if_pc(if_pc), .o_if_instr(if_instr), .o_if_valid(if_valid),
    .o_misalign(misalign), .o_fetch_cnt(fetch_cnt)
  );

  assign imem_rdata = mem[imem_addr[AW-1:2]];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: the architectural view of fetch, updated once per edge.
  bit          seen_rst = 0;
  bit          m_boot;
  int unsigned m_pc, m_ifpc, m_cnt;
  logic [31:0] m_instr;
  bit          m_valid, m_mis;

  always @(posedge clk) begin
    if (rst) begin
      seen_rst = 1; m_boot = 1; m_pc = 0; m_ifpc = 0; m_instr = NOP;
      m_valid = 0; m_mis = 0; m_cnt = 0;
    end else if (seen_rst) begin
      m_mis = 0;
      if (m_boot) m_boot = 0;
      else if (redirect) begin
        m_pc = (int'(redirect_pc) / 4) * 4;
        m_valid = 0; m_instr = NOP;
        m_mis = (redirect_pc % 4) != 0;
      end else if (!stall) begin
        m_ifpc = m_pc; m_instr = mem[m_pc / 4]; m_valid = 1;
        m_pc = (m_pc + 4) % (1 << AW);
        m_cnt = m_cnt + 1;
      end
    end
    #1;
    if (seen_rst) begin
      check("imem_addr", 64'(imem_addr), 64'(m_pc));
      check("if_pc", 64'(if_pc), 64'(m_ifpc));
      check("if_instr", 64'(if_instr), 64'(m_instr));
      check("if_valid", 64'(if_valid), 64'(m_valid));
      check("misalign", 64'(misalign), 64'(m_mis));
      check("fetch_cnt", 64'(fetch_cnt), 64'(m_cnt));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < (1 << (AW-2)); i++) mem[i] = $urandom;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_0113;
    // reset
    rst = 1; step(2);
    check("rst_addr", 64'(imem_addr), 64'h0);
    check("rst_instr", 64'(if_instr), 64'(NOP));
    check("rst_valid", 64'(if_valid), 64'h0);
    check("rst_cnt", 64'(fetch_cnt), 64'h0);
    rst = 0; step();
    check("boot_addr", 64'(imem_addr), 64'h0);
    check("boot_valid", 64'(if_valid), 64'h0);
    step();
    check("f0_instr", 64'(if_instr), 64'h0050_0093);
    check("f0_pc", 64'(if_pc), 64'h0);
    check("f0_valid", 64'(if_valid), 64'h1);
    step();
    check("f1_instr", 64'(if_instr), 64'h0010_0113);
    check("f1_pc", 64'(if_pc), 64'h4);
    check("cnt2", 64'(fetch_cnt), 64'h2);
    step(2);
    check("pre_stall_addr", 64'(imem_addr), 64'h10);
    // stall for 3 cycles at pc 0x10
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr", 64'(imem_addr), 64'h10);
      check("stall_ifpc", 64'(if_pc), 64'hC);
      check("stall_cnt", 64'(fetch_cnt), 64'h4);
    end
    stall = 0; step();
    check("resume_pc", 64'(if_pc), 64'h10);
    check("resume_instr", 64'(if_instr), 64'(mem[4]));
    check("resume_cnt", 64'(fetch_cnt), 64'h5);
    // redirect during stall
    stall = 1; redirect = 1; redirect_pc = 14'h40; step();
    check("rd_addr", 64'(imem_addr), 64'h40);
    check("rd_valid", 64'(if_valid), 64'h0);
    check("rd_instr", 64'(if_instr), 64'(NOP));
    check("rd_ifpc", 64'(if_pc), 64'h10);
    stall = 0; redirect = 0; step();
    check("rd_next_pc", 64'(if_pc), 64'h40);
    check("rd_next_valid", 64'(if_valid), 64'h1);
    // misaligned redirect
    redirect = 1; redirect_pc = 14'h22; step();
    check("mis_addr", 64'(imem_addr), 64'h20);
    check("mis_pulse", 64'(misalign), 64'h1);
    redirect = 0; step();
    check("mis_clear", 64'(misalign), 64'h0);
    check("mis_ifpc", 64'(if_pc), 64'h20);
    // PC wrap
    redirect = 1; redirect_pc = 14'h3FFC; step();
    redirect = 0; step();
    check("wrap_addr", 64'(imem_addr), 64'h0);
    check("wrap_ifpc", 64'(if_pc), 64'h3FFC);
    check("wrap_valid", 64'(if_valid), 64'h1);
    // reset beats simultaneous stall and redirect
    rst = 1; stall = 1; redirect = 1; redirect_pc = 14'h88; step();
    check("rst2_addr", 64'(imem_addr), 64'h0);
    check("rst2_ifpc", 64'(if_pc), 64'h0);
    check("rst2_cnt", 64'(fetch_cnt), 64'h0);
    rst = 0; step();
    check("boot2_valid", 64'(if_valid), 64'h0);
    check("boot2_addr", 64'(imem_addr), 64'h0);
    stall = 0; redirect = 0; step();
    check("boot2_fetch", 64'(if_instr), 64'h0050_0093);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 199) == 0);
      stall       = ($urandom_range(0, 3) == 0);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = AW'($urandom);
      step();
    end
    rst = 0; stall = 0; redirect = 0;
    step(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
